data_sampling: RTL and testbench

Receive-side bit recovery stage of the UART RX path. It synchronizes the raw serial line and counts oversampling edges and bit positions within a frame. At mid-bit it takes three samples and majority-votes them into one registered `sampled_bit`. The result goes to the downstream start/parity/stop checkers and the deserializer; those checkers depend on it being glitch-filtered and held stable between bit decisions.

---
 rtl/data_sampling_pkg.sv | 23 ++
 rtl/data_sampling_edge_bit_counter.sv | 48 ++++
 rtl/data_sampling.sv | 108 ++++++++++
 tb/tb_data_sampling.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sampling_pkg.sv
// Shared UART constants: legal oversampling ratios, default widths and the
// line idle level used by the RX sampler and the TX baud generator.
package data_sampling_pkg;

  localparam int PRESCALE_W_DEF = 6;
  localparam int BIT_CNT_W_DEF  = 4;

  typedef enum int {
    PRESCALE_X8  = 8,
    PRESCALE_X16 = 16,
    PRESCALE_X32 = 32
  } prescale_e;

  localparam int       PRESCALE_DEF = PRESCALE_X8;
  // Ratios below this are meaningless for a 3-sample mid-bit vote.
  localparam int       PRESCALE_MIN = 4;
  localparam logic     LINE_IDLE    = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/data_sampling_edge_bit_counter.sv
// Oversampling edge counter with a saturating bit counter; the edge count
// wraps at prescale-1 on the same clock edge that advances the bit count.
import data_sampling_pkg::*;

module edge_bit_counter #(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_edge_last
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  w_edge_last;
  logic                  w_bit_max;

  assign w_edge_last = (r_edge_cnt == i_prescale - PRESCALE_W'(1));
  assign w_bit_max   = &r_bit_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!i_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_edge_last) begin
      r_edge_cnt <= '0;
      if (!w_bit_max) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

  assign o_edge_cnt  = r_edge_cnt;
  assign o_bit_cnt   = r_bit_cnt;
  assign o_edge_last = w_edge_last;

endmodule

// File: rtl/data_sampling.sv
// UART RX bit recovery: synchronizes RX_IN, captures three mid-bit samples
// and publishes their majority as a registered, glitch-filtered bit.
import data_sampling_pkg::*;

module data_sampling #(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  cnt_en,
  input  logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_s2;
  logic                  r_sampled_bit;
  logic                  r_sample_valid;

  logic                  w_rx_s;
  logic [PRESCALE_W-1:0] w_prescale_eff;
  logic [PRESCALE_W-1:0] w_mid;
  logic                  w_edge_last;
  logic                  w_cap0;
  logic                  w_cap1;
  logic                  w_cap2;
  logic                  w_s2_next;
  logic                  w_vote_fire;

  assign w_prescale_eff = (Prescale < PRESCALE_W'(PRESCALE_MIN)) ? PRESCALE_W'(PRESCALE_DEF)
                                                                 : Prescale;
  assign w_mid          = w_prescale_eff >> 1;

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edge_bit_counter (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_en        (cnt_en),
    .i_prescale  (w_prescale_eff),
    .o_edge_cnt  (edge_cnt),
    .o_bit_cnt   (bit_cnt),
    .o_edge_last (w_edge_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= LINE_IDLE;
      r_sync2 <= LINE_IDLE;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  assign w_cap0    = (edge_cnt == w_mid - PRESCALE_W'(1));
  assign w_cap1    = (edge_cnt == w_mid);
  assign w_cap2    = (edge_cnt == w_mid + PRESCALE_W'(1));
  assign w_s2_next = w_cap2 ? w_rx_s : r_s2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s0 <= LINE_IDLE;
      r_s1 <= LINE_IDLE;
      r_s2 <= LINE_IDLE;
    end else if (!dat_samp_en) begin
      r_s0 <= LINE_IDLE;
      r_s1 <= LINE_IDLE;
      r_s2 <= LINE_IDLE;
    end else begin
      if (w_cap0) r_s0 <= w_rx_s;
      if (w_cap1) r_s1 <= w_rx_s;
      r_s2 <= w_s2_next;
    end
  end

  // The vote registers on the edge that enters mid+2, so the strobe and the new
  // bit are both visible during the mid+2 cycle; an enable drop cancels it.
  assign w_vote_fire = dat_samp_en & cnt_en & w_cap2 & ~w_edge_last;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sampled_bit  <= LINE_IDLE;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_vote_fire;
      if (w_vote_fire) begin
        r_sampled_bit <= majority3(r_s0, r_s1, w_s2_next);
      end
    end
  end

  assign sampled_bit  = r_sampled_bit;
  assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_data_sampling.sv
// Self-checking bench for data_sampling: a per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_data_sampling;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       cnt_en;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int n_checks = 0;
  int n_fail   = 0;

  data_sampling dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .cnt_en       (cnt_en),
    .dat_samp_en  (dat_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: line delay, integer counters and a three-slot sample array.
  int   m_line_d1, m_line_d2;
  int   m_edge, m_bit;
  int   m_samp[3];
  int   m_out, m_valid;
  int   mp, mmid, mones;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_line_d1 = 1; m_line_d2 = 1;
      m_edge = 0; m_bit = 0;
      m_samp = '{1, 1, 1};
      m_out = 1; m_valid = 0;
    end else begin
      mp   = (int'(Prescale) < 4) ? 8 : int'(Prescale);
      mmid = mp / 2;
      if (dat_samp_en) begin
        if (m_edge >= mmid - 1 && m_edge <= mmid + 1) m_samp[m_edge - mmid + 1] = m_line_d2;
      end else begin
        m_samp = '{1, 1, 1};
      end
      if (!cnt_en) begin
        m_edge = 0; m_bit = 0;
      end else if (m_edge == mp - 1) begin
        m_edge = 0;
        if (m_bit < 15) m_bit++;
      end else begin
        m_edge++;
      end
      m_valid = (dat_samp_en && m_edge == mmid + 2) ? 1 : 0;
      if (m_valid == 1) begin
        mones = m_samp[0] + m_samp[1] + m_samp[2];
        m_out = (mones >= 2) ? 1 : 0;
      end
      m_line_d2 = m_line_d1;
      m_line_d1 = int'(RX_IN);
    end
  end

  int pulse_count = 0;
  int last_pulse_edge = -1;

  always @(posedge CLK) begin
    #1;
    if (RST) begin
      check("model edge_cnt", 32'(edge_cnt), 32'(m_edge));
      check("model bit_cnt", 32'(bit_cnt), 32'(m_bit));
      check("model sampled_bit", 32'(sampled_bit), 32'(m_out));
      check("model sample_valid", 32'(sample_valid), 32'(m_valid));
      if (sample_valid) begin
        pulse_count++;
        last_pulse_edge = int'(edge_cnt);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_en(input logic c, input logic d);
    cnt_en = c;
    dat_samp_en = d;
  endtask

  int base;

  initial begin
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; set_en(1'b0, 1'b0);
    cycles(3);
    #1;
    check("reset sampled_bit", 32'(sampled_bit), 32'd1);
    check("reset sample_valid", 32'(sample_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #2;
    check("release sampled_bit", 32'(sampled_bit), 32'd1);
    check("release edge_cnt", 32'(edge_cnt), 32'd0);
    @(negedge CLK);

    // Clean zero at P=8: one pulse during edge 6 carrying 0.
    base = pulse_count;
    Prescale = 6'd8; RX_IN = 1'b0; set_en(1'b1, 1'b1);
    cycles(12);
    check("zero pulses", 32'(pulse_count - base), 32'd1);
    check("zero pulse edge", 32'(last_pulse_edge), 32'd6);
    check("zero sampled_bit", 32'(sampled_bit), 32'd0);
    set_en(1'b0, 1'b0); RX_IN = 1'b1;
    cycles(3);

    // Glitch at P=16: single low cycle lands in the edge-8 capture only.
    base = pulse_count;
    Prescale = 6'd16; set_en(1'b1, 1'b1);
    cycles(6); RX_IN = 1'b0;
    cycles(1); RX_IN = 1'b1;
    cycles(13);
    check("glitch pulses", 32'(pulse_count - base), 32'd1);
    check("glitch pulse edge", 32'(last_pulse_edge), 32'd10);
    check("glitch sampled_bit", 32'(sampled_bit), 32'd1);
    set_en(1'b0, 1'b0);
    cycles(2);

    // Frame counting at P=32 across ten bits.
    base = pulse_count;
    Prescale = 6'd32; RX_IN = 1'b0; set_en(1'b1, 1'b1);
    cycles(319);
    check("frame bit_cnt 9", 32'(bit_cnt), 32'd9);
    check("frame edge_cnt 31", 32'(edge_cnt), 32'd31);
    cycles(1);
    check("frame wrap bit_cnt", 32'(bit_cnt), 32'd10);
    check("frame wrap edge_cnt", 32'(edge_cnt), 32'd0);
    check("frame pulses", 32'(pulse_count - base), 32'd10);
    check("frame pulse edge", 32'(last_pulse_edge), 32'd18);
    check("frame sampled_bit", 32'(sampled_bit), 32'd0);
    set_en(1'b0, 1'b0);
    cycles(2);

    // Saturation at P=8, then clear on the next edge.
    base = pulse_count;
    Prescale = 6'd8; RX_IN = 1'b1; set_en(1'b1, 1'b0);
    cycles(163);
    check("sat bit_cnt", 32'(bit_cnt), 32'd15);
    check("sat edge_cnt", 32'(edge_cnt), 32'd3);
    check("sat no pulses", 32'(pulse_count - base), 32'd0);
    set_en(1'b0, 1'b0);
    @(posedge CLK); #2;
    check("clear edge_cnt", 32'(edge_cnt), 32'd0);
    check("clear bit_cnt", 32'(bit_cnt), 32'd0);
    @(negedge CLK);

    // Abort: dat_samp_en dropped at edge 4 keeps the old bit (0).
    base = pulse_count;
    set_en(1'b1, 1'b1);
    cycles(4);
    check("abort edge_cnt", 32'(edge_cnt), 32'd4);
    dat_samp_en = 1'b0;
    cycles(10);
    check("abort pulses", 32'(pulse_count - base), 32'd0);
    check("abort sampled_bit", 32'(sampled_bit), 32'd0);
    set_en(1'b0, 1'b0);
    cycles(2);

    // Illegal Prescale=2 behaves as P=8.
    base = pulse_count;
    Prescale = 6'd2; set_en(1'b1, 1'b1);
    cycles(7);
    check("p2 edge_cnt 7", 32'(edge_cnt), 32'd7);
    cycles(1);
    check("p2 wrap edge_cnt", 32'(edge_cnt), 32'd0);
    check("p2 wrap bit_cnt", 32'(bit_cnt), 32'd1);
    cycles(4);
    check("p2 pulses", 32'(pulse_count - base), 32'd1);
    check("p2 pulse edge", 32'(last_pulse_edge), 32'd6);
    check("p2 sampled_bit", 32'(sampled_bit), 32'd1);
    set_en(1'b0, 1'b0);
    cycles(2);

    // cnt_en dropped mid-bit discards the partial vote.
    base = pulse_count;
    Prescale = 6'd8; RX_IN = 1'b0; set_en(1'b1, 1'b1);
    cycles(5);
    cnt_en = 1'b0;
    @(posedge CLK); #2;
    check("drop edge_cnt", 32'(edge_cnt), 32'd0);
    cycles(8);
    check("drop pulses", 32'(pulse_count - base), 32'd0);
    check("drop sampled_bit", 32'(sampled_bit), 32'd1);
    set_en(1'b0, 1'b0);
    cycles(2);

    // Asynchronous reset mid-frame.
    set_en(1'b1, 1'b1);
    cycles(10);
    check("pre-reset sampled_bit", 32'(sampled_bit), 32'd0);
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    check("async edge_cnt", 32'(edge_cnt), 32'd0);
    check("async bit_cnt", 32'(bit_cnt), 32'd0);
    check("async sampled_bit", 32'(sampled_bit), 32'd1);
    check("async sample_valid", 32'(sample_valid), 32'd0);
    set_en(1'b0, 1'b0);
    cycles(2);
    RST = 1'b1;
    @(posedge CLK); #2;
    check("re-release edge_cnt", 32'(edge_cnt), 32'd0);
    check("re-release sampled_bit", 32'(sampled_bit), 32'd1);
    @(negedge CLK);
    set_en(1'b1, 1'b0);
    cycles(3);
    check("restart edge_cnt", 32'(edge_cnt), 32'd3);
    set_en(1'b0, 1'b0);
    cycles(2);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
